// File: rtl/at_poll_sched_pkg.sv
// Shared definitions for the AT-command poll scheduler: FSM encoding,
// command lengths and the ASCII markers used by the response matcher.
package at_poll_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_TX   = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_NEXT      = 3'd4
  } state_e;

  localparam int CMD0_LEN = 10;
  localparam int CMD1_LEN = 11;

  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/at_cmd_rom.sv
// Combinational byte table for the two poll commands:
// cmd 0 = "AT+SPO2?\r\n", cmd 1 = "AT+HEART?\r\n".
module at_cmd_rom
  import at_poll_sched_pkg::*;
(
  input  logic       cmd_id,
  input  logic [3:0] idx,
  output logic [7:0] cmd_byte
);

  always_comb begin
    cmd_byte = 8'h00;
    if (!cmd_id) begin
      case (idx)
        4'd0:    cmd_byte = 8'h41;
        4'd1:    cmd_byte = 8'h54;
        4'd2:    cmd_byte = ASCII_PLUS;
        4'd3:    cmd_byte = 8'h53;
        4'd4:    cmd_byte = 8'h50;
        4'd5:    cmd_byte = 8'h4F;
        4'd6:    cmd_byte = 8'h32;
        4'd7:    cmd_byte = 8'h3F;
        4'd8:    cmd_byte = ASCII_CR;
        4'd9:    cmd_byte = ASCII_LF;
        default: cmd_byte = 8'h00;
      endcase
    end else begin
      case (idx)
        4'd0:    cmd_byte = 8'h41;
        4'd1:    cmd_byte = 8'h54;
        4'd2:    cmd_byte = ASCII_PLUS;
        4'd3:    cmd_byte = 8'h48;
        4'd4:    cmd_byte = 8'h45;
        4'd5:    cmd_byte = 8'h41;
        4'd6:    cmd_byte = 8'h52;
        4'd7:    cmd_byte = 8'h54;
        4'd8:    cmd_byte = 8'h3F;
        4'd9:    cmd_byte = ASCII_CR;
        4'd10:   cmd_byte = ASCII_LF;
        default: cmd_byte = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/at_poll_sched.sv
// Periodic AT-command poller: sends SPO2 then HEART queries over a UART,
// waits for a '+'...CR response per command, retries on timeout, flags errors.
module at_poll_sched
  import at_poll_sched_pkg::*;
#(
  parameter int POLL_CYC = 50_000_000,
  parameter int TO_CYC   = 10_000_000,
  parameter int MAX_TRY  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_now,
  input  logic       tx_done,
  input  logic       Rx_done,
  input  logic [7:0] data_Byte,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       cmd_id,
  output logic       rx_gate,
  output logic       resp_ok,
  output logic [1:0] err,
  output logic       busy
);

  localparam int PC_W  = ($clog2(POLL_CYC) > 0) ? $clog2(POLL_CYC) : 1;
  localparam int TO_W  = ($clog2(TO_CYC) > 0) ? $clog2(TO_CYC) : 1;
  localparam int TRY_W = ($clog2(MAX_TRY + 1) > 0) ? $clog2(MAX_TRY + 1) : 1;

  localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(POLL_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRY - 1);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              armed_q, armed_d;
  logic              cmd_id_q, cmd_id_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              resp_ok_q, resp_ok_d;

  logic [7:0] rom_byte;
  logic [3:0] last_idx;
  logic       poll_due;
  logic       rx_plus;
  logic       rx_complete;
  logic       timeout;

  at_cmd_rom u_cmd_rom (
    .cmd_id   (cmd_id_q),
    .idx      (idx_q),
    .cmd_byte (rom_byte)
  );

  always_comb begin
    poll_due    = (poll_cnt_q == POLL_LAST);
    last_idx    = cmd_id_q ? 4'(CMD1_LEN - 1) : 4'(CMD0_LEN - 1);
    rx_plus     = Rx_done && (data_Byte == ASCII_PLUS);
    rx_complete = Rx_done && armed_q && (data_Byte == ASCII_CR);
    timeout     = (to_cnt_q == TO_LAST);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tries_d    = tries_q;
    to_cnt_d   = to_cnt_q;
    armed_d    = armed_q;
    cmd_id_d   = cmd_id_q;
    err_d      = err_q;
    tx_data_d  = tx_data_q;
    resp_ok_d  = 1'b0;

    // Free-running poll interval; a forced poll from IDLE restarts the period.
    poll_cnt_d = poll_due ? '0 : poll_cnt_q + PC_W'(1);
    if ((state_q == ST_IDLE) && req_now) poll_cnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (poll_due || req_now) begin
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data_d = rom_byte;
        state_d   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          if (idx_q == last_idx) begin
            idx_d    = '0;
            to_cnt_d = '0;
            armed_d  = 1'b0;
            state_d  = ST_WAIT_RESP;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SEND;
          end
        end
      end
      ST_WAIT_RESP: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Completion is tested first so it wins a tie with the timeout.
        if (rx_complete) begin
          resp_ok_d       = 1'b1;
          err_d[cmd_id_q] = 1'b0;
          tries_d         = '0;
          armed_d         = 1'b0;
          state_d         = ST_NEXT;
        end else if (timeout) begin
          armed_d  = 1'b0;
          to_cnt_d = '0;
          idx_d    = '0;
          if (tries_q >= TRY_LAST) begin
            err_d[cmd_id_q] = 1'b1;
            tries_d         = '0;
            state_d         = ST_NEXT;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            state_d = ST_SEND;
          end
        end else if (rx_plus) begin
          armed_d = 1'b1;
        end
      end
      ST_NEXT: begin
        cmd_id_d = ~cmd_id_q;
        idx_d    = '0;
        state_d  = cmd_id_q ? ST_IDLE : ST_SEND;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tries_q    <= '0;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      armed_q    <= 1'b0;
      cmd_id_q   <= 1'b0;
      err_q      <= 2'b00;
      tx_data_q  <= 8'h00;
      resp_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tries_q    <= tries_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      armed_q    <= armed_d;
      cmd_id_q   <= cmd_id_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      resp_ok_q  <= resp_ok_d;
    end
  end

  // The byte is presented straight from the ROM during the start pulse and
  // then held from the register until the UART reports it sent.
  always_comb begin
    tx_en   = (state_q == ST_SEND);
    tx_data = tx_en ? rom_byte : tx_data_q;
    rx_gate = (state_q == ST_WAIT_RESP);
    busy    = (state_q != ST_IDLE);
    resp_ok = resp_ok_q;
    err     = err_q;
    cmd_id  = cmd_id_q;
  end

endmodule

// File: tb/tb_at_poll_sched.sv
// Scenario bench for at_poll_sched: a UART TX model checks every transmitted
// byte against a queue of expected command bytes; tasks inject responses.
module tb_at_poll_sched;

  localparam int POLL_CYC = 2000;
  localparam int TO_CYC   = 300;
  localparam int MAX_TRY  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_now = 1'b0;
  logic       tx_done = 1'b0;
  logic       Rx_done = 1'b0;
  logic [7:0] data_Byte = 8'h00;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       cmd_id;
  logic       rx_gate;
  logic       resp_ok;
  logic [1:0] err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int tx_cnt = 0;
  int resp_cnt = 0;
  int cyc = 0;
  int poll_start = 0;

  logic [7:0] exp_q[$];
  logic [7:0] held_byte = 8'h00;
  int         tx_timer = 0;

  logic [7:0] cmd0_b [10] = '{8'h41, 8'h54, 8'h2B, 8'h53, 8'h50, 8'h4F, 8'h32, 8'h3F, 8'h0D, 8'h0A};
  logic [7:0] cmd1_b [11] = '{8'h41, 8'h54, 8'h2B, 8'h48, 8'h45, 8'h41, 8'h52, 8'h54, 8'h3F, 8'h0D, 8'h0A};
  logic [7:0] rsp0_b [9]  = '{8'h2B, 8'h53, 8'h50, 8'h4F, 8'h32, 8'h3D, 8'h39, 8'h38, 8'h0D};
  logic [7:0] rsp1_b [10] = '{8'h2B, 8'h48, 8'h45, 8'h41, 8'h52, 8'h54, 8'h3D, 8'h37, 8'h32, 8'h0D};
  logic [7:0] junk_b [3]  = '{8'h78, 8'h78, 8'h0D};

  at_poll_sched #(
    .POLL_CYC (POLL_CYC),
    .TO_CYC   (TO_CYC),
    .MAX_TRY  (MAX_TRY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_now   (req_now),
    .tx_done   (tx_done),
    .Rx_done   (Rx_done),
    .data_Byte (data_Byte),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .cmd_id    (cmd_id),
    .rx_gate   (rx_gate),
    .resp_ok   (resp_ok),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: pops the expected byte on each start pulse, checks the
  // byte stays put, and answers with tx_done 20 cycles later.
  always @(negedge clk) begin
    logic [7:0] want;
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_timer = 0;
    end else if (tx_en) begin
      tx_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte: got %02h at cycle %0d, no byte expected", tx_data, cyc);
      end else begin
        want = exp_q.pop_front();
        if (tx_data !== want) begin
          errors++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data, want);
        end
      end
      held_byte = tx_data;
      tx_timer  = 20;
    end else if (tx_timer > 0) begin
      checks++;
      if (tx_data !== held_byte) begin
        errors++;
        $display("FAIL tx_stable: got %02h, expected %02h", tx_data, held_byte);
      end
      tx_timer--;
      if (tx_timer == 0) tx_done = 1'b1;
    end
  end

  always @(negedge clk) if (resp_ok) resp_cnt++;

  task automatic push_cmd(input int c);
    if (c == 0) for (int i = 0; i < 10; i++) exp_q.push_back(cmd0_b[i]);
    else        for (int i = 0; i < 11; i++) exp_q.push_back(cmd1_b[i]);
  endtask

  // Ends on the negedge one cycle after the last byte's Rx_done.
  task automatic send_rx(input logic [7:0] b);
    repeat (2) @(negedge clk);
    Rx_done   = 1'b1;
    data_Byte = b;
    @(negedge clk);
    Rx_done   = 1'b0;
    data_Byte = 8'h00;
  endtask

  task automatic send_resp(input int which);
    case (which)
      0:       for (int i = 0; i < 9; i++)  send_rx(rsp0_b[i]);
      1:       for (int i = 0; i < 10; i++) send_rx(rsp1_b[i]);
      default: for (int i = 0; i < 3; i++)  send_rx(junk_b[i]);
    endcase
  endtask

  task automatic wait_gate(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rx_gate) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tx_en(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (tx_en) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_bit(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [15:0] got;
    got = {tx_data, tx_en, cmd_id, rx_gate, resp_ok, err, busy};
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL %s: outputs {tx_data,tx_en,cmd_id,rx_gate,resp_ok,err,busy}=%04h, expected 0000", tag, got);
    end
    checks++;
    if (tx_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: tx_en=%b busy=%b, expected 0 0", tag, tx_en, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_full_poll();
    bit ok;
    tx_cnt = 0;
    resp_cnt = 0;
    push_cmd(0);
    push_cmd(1);
    @(negedge clk);
    req_now = 1'b1;
    @(negedge clk);
    req_now = 1'b0;
    ok = tx_en;
    if (!ok) begin @(negedge clk); ok = tx_en; end
    poll_start = cyc;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_now_latency: tx_en=0 two cycles after req_now, expected 1");
    end
    repeat (50) @(negedge clk);
    req_now = 1'b1;
    @(negedge clk);
    req_now = 1'b0;
    wait_gate(1000, ok);
    check_bit("spo2_gate", ok);
    send_resp(0);
    checks++;
    if (resp_ok !== 1'b1 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL spo2_resp_ok: resp_ok=%b err=%b, expected resp_ok=1 err[0]=0", resp_ok, err);
    end
    @(negedge clk);
    checks++;
    if (cmd_id !== 1'b1 || resp_ok !== 1'b0) begin
      errors++;
      $display("FAIL spo2_next: cmd_id=%b resp_ok=%b, expected 1 0", cmd_id, resp_ok);
    end
    wait_gate(1000, ok);
    check_bit("heart_gate", ok);
    send_resp(2);
    checks++;
    if (resp_ok !== 1'b0 || rx_gate !== 1'b1) begin
      errors++;
      $display("FAIL junk_ignored: resp_ok=%b rx_gate=%b, expected 0 1", resp_ok, rx_gate);
    end
    send_resp(1);
    checks++;
    if (resp_ok !== 1'b1) begin
      errors++;
      $display("FAIL heart_resp_ok: resp_ok=%b, expected 1", resp_ok);
    end
    wait_idle(200, ok);
    check_bit("poll1_idle", ok);
    checks++;
    if (tx_cnt !== 21 || exp_q.size() != 0 || resp_cnt !== 2) begin
      errors++;
      $display("FAIL poll1_counts: tx_en=%0d left=%0d resp_ok=%0d, expected 21 0 2", tx_cnt, exp_q.size(), resp_cnt);
    end
    checks++;
    if (err !== 2'b00 || cmd_id !== 1'b0) begin
      errors++;
      $display("FAIL poll1_end: err=%b cmd_id=%b, expected 00 0", err, cmd_id);
    end
  endtask

  task automatic test_timeout_retry();
    bit ok;
    tx_cnt = 0;
    resp_cnt = 0;
    push_cmd(0);
    for (int t = 0; t < MAX_TRY; t++) push_cmd(1);
    wait_tx_en(2100, ok);
    check_bit("poll2_start", ok);
    checks++;
    if (cyc - poll_start !== POLL_CYC) begin
      errors++;
      $display("FAIL poll_interval: got %0d cycles, expected %0d", cyc - poll_start, POLL_CYC);
    end
    poll_start = cyc;
    wait_gate(1000, ok);
    check_bit("poll2_spo2_gate", ok);
    send_resp(0);
    wait_idle(1900, ok);
    check_bit("poll2_idle", ok);
    checks++;
    if (tx_cnt !== 10 + 11 * MAX_TRY || exp_q.size() != 0) begin
      errors++;
      $display("FAIL retry_count: tx_en=%0d left=%0d, expected %0d 0", tx_cnt, exp_q.size(), 10 + 11 * MAX_TRY);
    end
    checks++;
    if (err !== 2'b10 || resp_cnt !== 1 || cmd_id !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b resp_ok=%0d cmd_id=%b, expected 10 1 0", err, resp_cnt, cmd_id);
    end
  endtask

  task automatic test_err_clear();
    bit ok;
    tx_cnt = 0;
    push_cmd(0);
    push_cmd(1);
    wait_tx_en(2100, ok);
    check_bit("poll3_start", ok);
    wait_gate(1000, ok);
    check_bit("poll3_spo2_gate", ok);
    send_resp(0);
    checks++;
    if (resp_ok !== 1'b1 || err !== 2'b10) begin
      errors++;
      $display("FAIL err_hold: resp_ok=%b err=%b, expected 1 10", resp_ok, err);
    end
    wait_gate(1000, ok);
    check_bit("poll3_heart_gate", ok);
    send_resp(1);
    @(negedge clk);
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("FAIL err_clear: err=%b, expected 00", err);
    end
    wait_idle(200, ok);
    check_bit("poll3_idle", ok);
    checks++;
    if (tx_cnt !== 21 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL poll3_counts: tx_en=%0d left=%0d, expected 21 0", tx_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    tx_cnt = 0;
    push_cmd(0);
    @(negedge clk);
    req_now = 1'b1;
    @(negedge clk);
    req_now = 1'b0;
    for (int i = 0; i < 200 && tx_cnt < 3; i++) @(negedge clk);
    check_bit("mid_tx_progress", tx_cnt >= 3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    tx_cnt = 0;
    push_cmd(0);
    push_cmd(1);
    repeat (1990) @(negedge clk);
    checks++;
    if (tx_cnt !== 0) begin
      errors++;
      $display("FAIL no_tx_after_reset: tx_en=%0d, expected 0", tx_cnt);
    end
    wait_tx_en(30, ok);
    check_bit("poll_after_reset", ok);
    wait_gate(1000, ok);
    check_bit("poll4_spo2_gate", ok);
    send_resp(0);
    wait_gate(1000, ok);
    check_bit("poll4_heart_gate", ok);
    send_resp(1);
    wait_idle(200, ok);
    check_bit("poll4_idle", ok);
    checks++;
    if (tx_cnt !== 21 || exp_q.size() != 0 || err !== 2'b00) begin
      errors++;
      $display("FAIL poll4_counts: tx_en=%0d left=%0d err=%b, expected 21 0 00", tx_cnt, exp_q.size(), err);
    end
  endtask

  initial begin
    test_reset();
    test_full_poll();
    test_timeout_retry();
    test_err_clear();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
